// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared constants for the PS/2 mouse tracker: packet bit positions, FSM states
// and the video register indices this block writes.
package ps2_mouse_tracker_pkg;

  localparam int PKT_LEFT     = 0;
  localparam int PKT_RIGHT    = 1;
  localparam int PKT_MIDDLE   = 2;
  localparam int PKT_ALWAYS_1 = 3;
  localparam int PKT_X_SIGN   = 4;
  localparam int PKT_Y_SIGN   = 5;
  localparam int PKT_X_OVF    = 6;
  localparam int PKT_Y_OVF    = 7;

  // Register selects shared with the video controller register file
  localparam logic [3:0] VIDEO_NOP            = 4'h0;
  localparam logic [3:0] VIDEO_MOUSE_POSITION = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BYTE2  = 3'd1,
    ST_BYTE3  = 3'd2,
    ST_BYTE4  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_SEND   = 3'd5
  } state_t;

  function automatic logic is_packet_state(input state_t s);
    return (s == ST_BYTE2) || (s == ST_BYTE3) || (s == ST_BYTE4);
  endfunction

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// Byte-receiver input and pointer/video-register outputs of the mouse tracker.
// The slave modport is the tracker; the master modport is its environment.
interface ps2_mouse_tracker_if #(
  parameter int X_WIDTH      = 11,
  parameter int Y_WIDTH      = 10,
  parameter int TEXT_X_SHIFT = 4,
  parameter int TEXT_Y_SHIFT = 4
);
  logic                           scan_code_ready;
  logic [7:0]                     scan_code_in;
  logic                           mouse_state_ready;
  logic                           button_left;
  logic                           button_middle;
  logic                           button_right;
  logic [X_WIDTH-1:0]             x_screen;
  logic [Y_WIDTH-1:0]             y_screen;
  logic [X_WIDTH-TEXT_X_SHIFT-1:0] x_text;
  logic [Y_WIDTH-TEXT_Y_SHIFT-1:0] y_text;
  logic [3:0]                     wheel_delta;
  logic                           sync_error;
  logic [3:0]                     register_index;
  logic [22:0]                    register_value;

  modport master (
    output scan_code_ready, scan_code_in,
    input  mouse_state_ready, button_left, button_middle, button_right,
           x_screen, y_screen, x_text, y_text, wheel_delta, sync_error,
           register_index, register_value
  );

  modport slave (
    input  scan_code_ready, scan_code_in,
    output mouse_state_ready, button_left, button_middle, button_right,
           x_screen, y_screen, x_text, y_text, wheel_delta, sync_error,
           register_index, register_value
  );
endinterface

// File: rtl/ps2_mouse_tracker_axis.sv
// One pointer axis: sign-extend the 9-bit delta, zero it on overflow, scale,
// apply (optionally inverted) and clamp the result to 0..MAX.
module ps2_mouse_axis #(
  parameter int WIDTH        = 11,
  parameter int MAX          = 1279,
  parameter int MOTION_SHIFT = 0,
  parameter bit INVERT       = 1'b0
) (
  input  logic [WIDTH-1:0] pos,
  input  logic [8:0]       delta,
  input  logic             overflow,
  output logic [WIDTH-1:0] pos_next
);
  localparam int W = WIDTH + 2;
  localparam logic signed [W-1:0] MAX_S = W'(MAX);

  logic signed [W-1:0] delta_ext;
  logic signed [W-1:0] scaled;
  logic signed [W-1:0] pos_ext;
  logic signed [W-1:0] sum;

  always_comb begin
    delta_ext = overflow ? '0 : {{(W-9){delta[8]}}, delta};
    scaled    = delta_ext <<< MOTION_SHIFT;
    pos_ext   = {2'b00, pos};
    sum       = INVERT ? (pos_ext - scaled) : (pos_ext + scaled);
    if (sum[W-1])
      pos_next = '0;
    else if (sum > MAX_S)
      pos_next = WIDTH'(MAX);
    else
      pos_next = sum[WIDTH-1:0];
  end
endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet assembler and absolute pointer tracker; publishes the
// pointer position to the video controller register bus after each packet.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for byte 1 (strobe or pending byte), bit3 must be 1
// ST_BYTE2  | waiting for X byte, inter-byte timeout armed
// ST_BYTE3  | waiting for Y byte, inter-byte timeout armed
// ST_BYTE4  | waiting for wheel byte (only when WHEEL_ENABLE=1)
// ST_UPDATE | apply deltas, latch buttons, position, text and register outputs
// ST_SEND   | mouse_state_ready high for one cycle
module ps2_mouse_tracker
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int MAX_X          = 1279,
  parameter int MAX_Y          = 1023,
  parameter int X_WIDTH        = 11,
  parameter int Y_WIDTH        = 10,
  parameter int TEXT_X_SHIFT   = 4,
  parameter int TEXT_Y_SHIFT   = 4,
  parameter int MOTION_SHIFT   = 0,
  parameter bit WHEEL_ENABLE   = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  ps2_mouse_tracker_if.slave  bus
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  generate
    if (X_WIDTH + Y_WIDTH > 23) begin : g_width_check
      $error("ps2_mouse_tracker: X_WIDTH + Y_WIDTH must not exceed 23");
    end
  endgenerate

  state_t                          state;
  logic [7:0]                      byte1, byte2, byte3, byte4;
  logic [7:0]                      pend_byte;
  logic                            pend_valid;
  logic [TW-1:0]                   timer;
  logic [X_WIDTH-1:0]              x_q, x_next;
  logic [Y_WIDTH-1:0]              y_q, y_next;
  logic [X_WIDTH-TEXT_X_SHIFT-1:0] x_text_q;
  logic [Y_WIDTH-TEXT_Y_SHIFT-1:0] y_text_q;
  logic                            left_q, middle_q, right_q;
  logic [3:0]                      wheel_q;
  logic                            ready_q, sync_q;
  logic [3:0]                      reg_idx_q;
  logic [22:0]                     reg_val_q;

  logic       strobe;
  logic       in_packet;
  logic       timeout;
  logic [7:0] cand;

  assign strobe    = bus.scan_code_ready;
  assign in_packet = is_packet_state(state);
  assign timeout   = in_packet && !strobe && (timer == '0);
  assign cand      = strobe ? bus.scan_code_in : pend_byte;

  ps2_mouse_axis #(
    .WIDTH(X_WIDTH), .MAX(MAX_X), .MOTION_SHIFT(MOTION_SHIFT), .INVERT(1'b0)
  ) u_axis_x (
    .pos(x_q), .delta({byte1[PKT_X_SIGN], byte2}),
    .overflow(byte1[PKT_X_OVF]), .pos_next(x_next)
  );

  // PS/2 reports positive Y as upward, screen rows grow downward
  ps2_mouse_axis #(
    .WIDTH(Y_WIDTH), .MAX(MAX_Y), .MOTION_SHIFT(MOTION_SHIFT), .INVERT(1'b1)
  ) u_axis_y (
    .pos(y_q), .delta({byte1[PKT_Y_SIGN], byte3}),
    .overflow(byte1[PKT_Y_OVF]), .pos_next(y_next)
  );

  // Inter-byte timer: reloads on every strobe and whenever no packet is open
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      timer <= TIMER_LOAD;
    else if (strobe || !in_packet || (timer == '0))
      timer <= TIMER_LOAD;
    else
      timer <= timer - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      byte1      <= '0;
      byte2      <= '0;
      byte3      <= '0;
      byte4      <= '0;
      pend_byte  <= '0;
      pend_valid <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      x_text_q   <= '0;
      y_text_q   <= '0;
      left_q     <= 1'b0;
      middle_q   <= 1'b0;
      right_q    <= 1'b0;
      wheel_q    <= '0;
      ready_q    <= 1'b0;
      sync_q     <= 1'b0;
      reg_idx_q  <= VIDEO_NOP;
      reg_val_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      sync_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strobe || pend_valid) begin
            pend_valid <= 1'b0;
            if (cand[PKT_ALWAYS_1]) begin
              byte1 <= cand;
              state <= ST_BYTE2;
            end else begin
              sync_q <= 1'b1;
            end
          end
        end
        ST_BYTE2: begin
          if (strobe) begin
            byte2 <= bus.scan_code_in;
            state <= ST_BYTE3;
          end else if (timeout) begin
            sync_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_BYTE3: begin
          if (strobe) begin
            byte3 <= bus.scan_code_in;
            state <= WHEEL_ENABLE ? ST_BYTE4 : ST_UPDATE;
          end else if (timeout) begin
            sync_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_BYTE4: begin
          if (strobe) begin
            byte4 <= bus.scan_code_in;
            state <= ST_UPDATE;
          end else if (timeout) begin
            sync_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          if (strobe) begin
            pend_byte  <= bus.scan_code_in;
            pend_valid <= 1'b1;
          end
          left_q    <= byte1[PKT_LEFT];
          right_q   <= byte1[PKT_RIGHT];
          middle_q  <= byte1[PKT_MIDDLE];
          x_q       <= x_next;
          y_q       <= y_next;
          x_text_q  <= x_next[X_WIDTH-1:TEXT_X_SHIFT];
          y_text_q  <= y_next[Y_WIDTH-1:TEXT_Y_SHIFT];
          wheel_q   <= WHEEL_ENABLE ? byte4[3:0] : 4'd0;
          reg_idx_q <= VIDEO_MOUSE_POSITION;
          reg_val_q <= 23'({y_next, x_next});
          ready_q   <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (strobe) begin
            pend_byte  <= bus.scan_code_in;
            pend_valid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mouse_state_ready = ready_q;
  assign bus.button_left       = left_q;
  assign bus.button_middle     = middle_q;
  assign bus.button_right      = right_q;
  assign bus.x_screen          = x_q;
  assign bus.y_screen          = y_q;
  assign bus.x_text            = x_text_q;
  assign bus.y_text            = y_text_q;
  assign bus.wheel_delta       = wheel_q;
  assign bus.sync_error        = sync_q;
  assign bus.register_index    = reg_idx_q;
  assign bus.register_value    = reg_val_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: a 3-byte instance driven from a vector
// table plus hand sequences, and a 4-byte wheel instance with MOTION_SHIFT=1.
module tb_ps2_mouse_tracker;
  import ps2_mouse_tracker_pkg::*;

  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_mouse_tracker_if m0();
  ps2_mouse_tracker_if m1();

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TMO)) dut0 (.clk(clk), .reset(rst_n), .bus(m0));
  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TMO), .WHEEL_ENABLE(1'b1), .MOTION_SHIFT(1))
    dut1 (.clk(clk), .reset(rst_n), .bus(m1));

  typedef struct {
    logic [7:0] b1, b2, b3;
    logic l, m, r;
    int x, y;
  } vec_t;

  vec_t vecs[18];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    if (d == 0) begin
      m0.scan_code_in = b;
      m0.scan_code_ready = 1'b1;
    end else begin
      m1.scan_code_in = b;
      m1.scan_code_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    m0.scan_code_ready = 1'b0;
    m1.scan_code_ready = 1'b0;
  endtask

  task automatic get(input int d, output logic rdy, output logic sync,
                     output logic l, output logic m, output logic r,
                     output int x, output int y, output int xt, output int yt,
                     output int wh, output int ri, output int rv);
    if (d == 0) begin
      rdy = m0.mouse_state_ready; sync = m0.sync_error;
      l = m0.button_left; m = m0.button_middle; r = m0.button_right;
      x = int'(m0.x_screen); y = int'(m0.y_screen);
      xt = int'(m0.x_text); yt = int'(m0.y_text); wh = int'(m0.wheel_delta);
      ri = int'(m0.register_index); rv = int'(m0.register_value);
    end else begin
      rdy = m1.mouse_state_ready; sync = m1.sync_error;
      l = m1.button_left; m = m1.button_middle; r = m1.button_right;
      x = int'(m1.x_screen); y = int'(m1.y_screen);
      xt = int'(m1.x_text); yt = int'(m1.y_text); wh = int'(m1.wheel_delta);
      ri = int'(m1.register_index); rv = int'(m1.register_value);
    end
  endtask

  // Called right after the last byte's strobe edge
  task automatic finish_packet(input int d, input string tag, input int ex, input int ey,
                               input logic el, input logic em, input logic er, input int ewh);
    logic rdy, sync, l, m, r;
    int x, y, xt, yt, wh, ri, rv;
    get(d, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check({tag, ".ready_early"}, int'(rdy), 0);
    tick();
    get(d, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check({tag, ".ready"}, int'(rdy), 1);
    check({tag, ".sync"}, int'(sync), 0);
    check({tag, ".left"}, int'(l), int'(el));
    check({tag, ".middle"}, int'(m), int'(em));
    check({tag, ".right"}, int'(r), int'(er));
    check({tag, ".x"}, x, ex);
    check({tag, ".y"}, y, ey);
    check({tag, ".x_text"}, xt, ex / 16);
    check({tag, ".y_text"}, yt, ey / 16);
    check({tag, ".wheel"}, wh, ewh);
    check({tag, ".reg_idx"}, ri, int'(VIDEO_MOUSE_POSITION));
    check({tag, ".reg_val"}, rv, ey * 2048 + ex);
    tick();
    get(d, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check({tag, ".ready_drop"}, int'(rdy), 0);
    check({tag, ".reg_hold"}, rv, ey * 2048 + ex);
  endtask

  task automatic send_packet(input int d, input string tag,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4,
                             input int ex, input int ey,
                             input logic el, input logic em, input logic er, input int ewh);
    send_byte(d, b1); tick(); tick();
    send_byte(d, b2); tick(); tick();
    send_byte(d, b3);
    if (d == 1) begin
      tick(); tick();
      send_byte(d, b4);
    end
    finish_packet(d, tag, ex, ey, el, em, er, ewh);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy, sync, l, m, r;
    int x, y, xt, yt, wh, ri, rv;
    int hit;
    int saw_ready;

    vecs[0]  = '{8'h09, 8'h10, 8'h05, 1, 0, 0,   16,    0};
    vecs[1]  = '{8'h28, 8'h00, 8'h9C, 0, 0, 0,   16,  100};
    vecs[2]  = '{8'h18, 8'h80, 8'h00, 0, 0, 0,    0,  100};
    vecs[3]  = '{8'h08, 8'hFF, 8'h00, 0, 0, 0,  255,  100};
    vecs[4]  = '{8'h08, 8'hFF, 8'h00, 0, 0, 0,  510,  100};
    vecs[5]  = '{8'h08, 8'hFF, 8'h00, 0, 0, 0,  765,  100};
    vecs[6]  = '{8'h08, 8'hFF, 8'h00, 0, 0, 0, 1020,  100};
    vecs[7]  = '{8'h08, 8'hFF, 8'h00, 0, 0, 0, 1275,  100};
    vecs[8]  = '{8'h08, 8'hFF, 8'h00, 0, 0, 0, 1279,  100};
    vecs[9]  = '{8'h0E, 8'h00, 8'h00, 0, 1, 1, 1279,  100};
    vecs[10] = '{8'h08, 8'h00, 8'h7F, 0, 0, 0, 1279,    0};
    vecs[11] = '{8'h28, 8'h00, 8'hCE, 0, 0, 0, 1279,   50};
    vecs[12] = '{8'h49, 8'h80, 8'h05, 1, 0, 0, 1279,   45};
    vecs[13] = '{8'h98, 8'hF6, 8'h50, 0, 0, 0, 1269,   45};
    vecs[14] = '{8'h28, 8'h00, 8'h00, 0, 0, 0, 1269,  301};
    vecs[15] = '{8'h28, 8'h00, 8'h00, 0, 0, 0, 1269,  557};
    vecs[16] = '{8'h28, 8'h00, 8'h00, 0, 0, 0, 1269,  813};
    vecs[17] = '{8'h28, 8'h00, 8'h00, 0, 0, 0, 1269, 1023};

    m0.scan_code_ready = 1'b0; m0.scan_code_in = 8'h00;
    m1.scan_code_ready = 1'b0; m1.scan_code_in = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    get(0, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check("reset.x", x, 0);
    check("reset.reg_idx", ri, int'(VIDEO_NOP));
    check("reset.ready", int'(rdy), 0);
    check("reset.other", int'(sync | l | m | r) + y + xt + yt + wh + rv, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      send_packet(0, $sformatf("vec%0d", i), vecs[i].b1, vecs[i].b2, vecs[i].b3, 8'h00,
                  vecs[i].x, vecs[i].y, vecs[i].l, vecs[i].m, vecs[i].r, 0);

    // Byte 1 without the always-one bit is dropped
    send_byte(0, 8'h01);
    get(0, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check("resync.pulse", int'(sync), 1);
    check("resync.ready", int'(rdy), 0);
    tick();
    get(0, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check("resync.pulse_end", int'(sync), 0);
    tick();
    send_packet(0, "after_resync", 8'h08, 8'h01, 8'h01, 8'h00, 1270, 1022, 0, 0, 0, 0);

    // Inter-byte timeout after byte 2
    send_byte(0, 8'h08); tick(); tick();
    send_byte(0, 8'h05);
    hit = 0;
    saw_ready = 0;
    for (int k = 1; k <= 3 * TMO; k++) begin
      tick();
      get(0, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
      if (rdy) saw_ready = 1;
      if (sync) begin
        hit = k;
        break;
      end
    end
    check("timeout.cycles", hit, TMO);
    check("timeout.no_ready", saw_ready, 0);
    check("timeout.x_kept", x, 1270);
    tick();
    send_packet(0, "after_timeout", 8'h08, 8'h02, 8'h00, 8'h00, 1272, 1022, 0, 0, 0, 0);

    // Byte 1 of the next packet arrives while SEND is active
    send_byte(0, 8'h08); tick(); tick();
    send_byte(0, 8'h01); tick(); tick();
    send_byte(0, 8'h00);
    tick();
    get(0, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check("pend.first_ready", int'(rdy), 1);
    check("pend.first_x", x, 1273);
    send_byte(0, 8'h08);
    tick();
    tick();
    send_byte(0, 8'h03); tick(); tick();
    send_byte(0, 8'h00);
    finish_packet(0, "pend.second", 1276, 1022, 0, 0, 0, 0);

    // Wheel instance, deltas doubled
    send_packet(1, "w0", 8'h28, 8'h00, 8'hF6, 8'h00, 0, 20, 0, 0, 0, 0);
    send_packet(1, "w1", 8'h48, 8'h7F, 8'h02, 8'h0F, 0, 16, 0, 0, 0, 15);
    send_packet(1, "w2", 8'h08, 8'h00, 8'h0A, 8'h00, 0, 0, 0, 0, 0, 0);
    send_packet(1, "w3", 8'h08, 8'h05, 8'h00, 8'h0E, 10, 0, 0, 0, 0, 14);

    // Reset in the middle of a packet
    send_byte(1, 8'h28);
    rst_n = 1'b0;
    #1;
    get(1, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check("midreset.x", x, 0);
    check("midreset.wheel", wh, 0);
    check("midreset.reg_val", rv, 0);
    check("midreset.reg_idx", ri, int'(VIDEO_NOP));
    get(0, rdy, sync, l, m, r, x, y, xt, yt, wh, ri, rv);
    check("midreset.dut0_x", x, 0);
    check("midreset.dut0_y", y, 0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    send_packet(1, "after_reset", 8'h28, 8'h00, 8'hFE, 8'h01, 0, 4, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
- Parametrised successor to the PS/2 mouse state decoder.
- Assembles standard 3-byte packets (or 4-byte IntelliMouse packets when WHEEL_ENABLE=1) from the PS/2 byte receiver.
- Validates packet framing; uses full 9-bit signed deltas with overflow handling; clamps an absolute pointer to a configurable screen; reports wheel motion.
- Publishes the pointer position to the video controller register bus.

Parameters:
- MAX_X, 1279, rightmost pixel column.
- MAX_Y, 1023, bottom pixel row.
- X_WIDTH, 11, width of x_screen.
- Y_WIDTH, 10, width of y_screen.
- TEXT_X_SHIFT, 4, x_text = x_screen >> TEXT_X_SHIFT.
- TEXT_Y_SHIFT, 4, y_text = y_screen >> TEXT_Y_SHIFT.
- MOTION_SHIFT, 0, deltas are multiplied by 2^MOTION_SHIFT before applying.
- WHEEL_ENABLE, 0, 1 selects 4-byte packets.
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one packet.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- scan_code_ready  in  1  one-cycle strobe: byte valid
- scan_code_in  in  8  received byte
- mouse_state_ready  out  1  one-cycle pulse: outputs updated
- button_left / button_middle / button_right  out  1 each  button state
- x_screen  out  X_WIDTH  pointer column
- y_screen  out  Y_WIDTH  pointer row
- x_text  out  X_WIDTH-TEXT_X_SHIFT  text column
- y_text  out  Y_WIDTH-TEXT_Y_SHIFT  text row
- wheel_delta  out  4  signed wheel motion of last packet
- sync_error  out  1  one-cycle pulse: packet dropped
- register_index  out  4  video register select
- register_value  out  23  video register data

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, state IDLE.
  - register_index = VIDEO_NOP.
  - Pending-byte flag cleared.
  - A reset asserted mid-packet discards the partial packet.
- States: IDLE, BYTE2, BYTE3, BYTE4, UPDATE, SEND. BYTE4 is skipped when WHEEL_ENABLE=0.
- IDLE: a byte (strobe, or pending byte) is accepted as byte 1 only if bit3=1.
  - Accepted: go to BYTE2.
  - Rejected: stay in IDLE and pulse sync_error (resynchronisation).
- BYTE2, BYTE3, BYTE4: each strobe captures the next byte and advances. The last byte moves the FSM to UPDATE.
- Timeout: the inter-byte counter clears on every strobe. In BYTE2..BYTE4, if the counter reaches TIMEOUT_CYCLES-1 with no strobe:
  - discard the packet;
  - pulse sync_error;
  - go to IDLE.
- UPDATE:
  - Buttons take byte1 bits 0 (left), 1 (right), 2 (middle).
  - dx = signed {byte1[4], byte2}; dy = signed {byte1[5], byte3}. Both are 9-bit, range -256..255.
  - Overflow: byte1[6] set forces dx=0; byte1[7] set forces dy=0. Buttons still update.
  - Scaling: delta <<= MOTION_SHIFT, computed at X_WIDTH+2 / Y_WIDTH+2 bits signed.
  - x_new = x + dx; y_new = y - dy (PS/2 positive Y is upward).
  - Clamp: below 0 gives 0; above MAX gives MAX.
  - wheel_delta = byte4[3:0] when WHEEL_ENABLE=1, else 0.
- SEND (one cycle), then IDLE:
  - mouse_state_ready = 1.
  - x_text and y_text are updated.
  - register_index = VIDEO_MOUSE_POSITION.
  - register_value = zero-extended {y_screen, x_screen}. X_WIDTH+Y_WIDTH <= 23 is an elaboration check.
- Steady state between packets:
  - mouse_state_ready = 0 in all other states.
  - register_index and register_value hold until the next SEND.
  - sync_error is a one-cycle pulse.
- Latency: mouse_state_ready rises 2 cycles after the strobe of the last packet byte.
- Strobe during UPDATE or SEND: the byte goes into a one-deep pending register and is evaluated as a byte-1 candidate on the first IDLE cycle. A second strobe while the pending register is full overwrites it.
- Input assumption: strobes are never closer than 3 cycles apart.

Decomposition:
- Shared package, mouse_constants.v:
  - packet bit indices (buttons, ALWAYS_1, X/Y sign, X/Y overflow);
  - state encodings.
- VIDEO_MOUSE_POSITION and VIDEO_NOP come from the existing video_controller/registers.v.
- Sub-module ps2_mouse_axis, instantiated twice (x, y): combinational sign-extend, overflow zeroing, shift, add/subtract and clamp. Parameters: WIDTH, MAX, MOTION_SHIFT, INVERT.

Test Plan:
- Reset, then bytes 0x09,0x10,0x05 -> left=1; x_screen=16; y_screen=0 (clamped); ready 2 cycles after third strobe; register_value=0x000010.
- From x=16, y=0: bytes 0x28,0x00,0x9C (dy=-100) -> x=16, y=100, y_text=6.
- Bytes 0x18,0x80,0x00 (dx=-128) from x=16 -> x_screen=0. Then 1280 pixels of +dx -> x_screen=1279, x_text=79.
- Byte 0x01 (bit3=0) -> sync_error pulse, no ready. Then 0x08,0x01,0x01 -> normal update, x+1, y-1 (clamped to 0 if y was 0).
- Bytes 0x08,0x05, then TIMEOUT_CYCLES idle clocks -> sync_error pulse, FSM in IDLE. Next valid packet decodes correctly.
- WHEEL_ENABLE=1, MOTION_SHIFT=1: bytes 0x48,0x7F,0x02,0x0F -> dx forced 0 (overflow); y decreases by 4 (dy=2 scaled), clamped at 0 when starting from 0; wheel_delta=-1. Reset asserted mid-packet -> all outputs 0 immediately.
